ws_write_block: RTL
===================

Name: ws_write_block

Overview:
- Write-back counterpart of the S' fetch path in milestone 2.
- Per start pulse, reads one 8x8 block of reconstructed 32-bit signed S values from DPRAM, clips each value to 8 bits, packs two pixels per 16-bit word and writes 32 words to SRAM.
- Tracks its own block position across the Y, U and V segments of the output image.
- Sits between the IDCT DPRAM and the SRAM arbiter; the M2 FSM drives it.

Parameters:
- DP_OFFSET, 7'd0, DPRAM base of the S block (lower half of DPRAM).
- Y_BASE, 18'd0, SRAM word address of the Y segment.
- U_BASE, 18'd38400, SRAM word address of the U segment.
- V_BASE, 18'd57600, SRAM word address of the V segment.

Ports:
- CLOCK_50_I  in  1  50 MHz clock.
- Reset  in  1  asynchronous, active-high reset.
- WS_start  in  1  one-cycle start request, sampled in IDLE.
- WS_done  out  1  one-cycle pulse after the 32nd SRAM write.
- WS_frame_done  out  1  one-cycle pulse, coincident with WS_done, on the last V block.
- WS_read_address  out  7  DPRAM read address.
- WS_read_data  in  32  DPRAM read data; valid one cycle after the address.
- SRAM_address  out  18  SRAM word address.
- SRAM_write_data  out  16  {even pixel[15:8], odd pixel[7:0]}.
- SRAM_we_n  out  1  active-low write enable.

Behaviour:
- Reset values:
  - WS_done = 0, WS_frame_done = 0, SRAM_we_n = 1.
  - SRAM_address = 0, SRAM_write_data = 0, WS_read_address = DP_OFFSET.
  - Block counters CB = 0, RB = 0, segment = Y.
  - State = IDLE.
- Reset mid-block: the block is aborted, nothing is resumed, and SRAM_we_n goes to 1 immediately.
- States: IDLE, LI (lead-in), COMMON, LO (lead-out).
- Cycle numbering: cycle 0 is the cycle WS_start is sampled high in IDLE.
- DPRAM reads:
  - Index k (0..63) is presented as WS_read_address = DP_OFFSET + k during cycle k+1.
  - Its data is captured at the end of cycle k+2.
- Clip rule on signed 32-bit S: S < 0 gives 8'd0; S > 255 gives 8'd255; otherwise S[7:0].
- Packing:
  - Even index 2j is clipped and held.
  - When odd index 2j+1 arrives, word j = {clip(S[2j]), clip(S[2j+1])}.
- SRAM write timing:
  - Word j is driven in cycle 2j+4 with SRAM_we_n = 0, all outputs registered.
  - SRAM_we_n = 1 on every other cycle of the block.
  - 32 writes total; the last write is in cycle 66.
- Completion:
  - WS_done = 1 in cycle 67 and the FSM is back in IDLE that cycle.
  - A WS_start in cycle 67 is accepted.
- WS_start outside IDLE is ignored; there is no queueing.
- Word address, with r = j[4:2] (row in block) and w = j[1:0]:
  - Y segment: Y_BASE + (8*RB + r)*160 + 4*CB + w.
  - U/V segment: base + (8*RB + r)*80 + 4*CB + w.
  - The multiplies are implemented as shift-adds (160 = 128 + 32, 80 = 64 + 16).
- Block advance, in cycle 66:
  - CB increments until C_END (39 for Y, 19 for U/V), then CB wraps to 0 and RB increments.
  - At RB = 29 with CB = C_END, RB wraps to 0 and the segment advances Y -> U -> V -> Y.
  - On the V -> Y wrap, WS_frame_done pulses with WS_done.
- Width rules: all address arithmetic is 18-bit unsigned with no overflow; the maximum address is 76799.

Test Plan:
- Clip check: DPRAM[0..3] = -5, 300, 255, 0 -> word 0 = 16'h00FF and word 1 = 16'hFF00. First write at cycle 4 to SRAM_address 0, second write at cycle 6 to address 1.
- First Y block: words land at 0..3, 160..163, ..., 1120..1123. WS_done pulses at cycle 67; exactly 32 cycles have SRAM_we_n = 0.
- Y-to-U wrap: block RB = 29, CB = 39 ends at address 38399. The next block's first write is at 38400 (U, CB = 0, RB = 0).
- Frame wrap: the last V block's final write is at 76799 and WS_frame_done pulses. The next block writes address 0.
- Back-to-back and busy-start: WS_start held high continuously -> blocks start in cycles 0, 67, 134, ... Starts asserted in cycles 1..66 have no effect.
- Reset asserted in cycle 30 -> SRAM_we_n = 1 and all outputs at reset values asynchronously. After reset release, the next start writes block (0,0) of Y.

Source files
------------

// File: rtl/ws_write_block_if.sv
// Handshake, DPRAM read port and SRAM write port of the S' write-back block.
interface ws_write_block_if;
    localparam int unsigned DP_AW   = 7;
    localparam int unsigned DP_DW   = 32;
    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned SRAM_DW = 16;

    logic               WS_start;
    logic               WS_done;
    logic               WS_frame_done;
    logic [DP_AW-1:0]   WS_read_address;
    logic [DP_DW-1:0]   WS_read_data;
    logic [SRAM_AW-1:0] SRAM_address;
    logic [SRAM_DW-1:0] SRAM_write_data;
    logic               SRAM_we_n;

    // master: the write-back block itself
    modport master (
        input  WS_start, WS_read_data,
        output WS_done, WS_frame_done, WS_read_address,
               SRAM_address, SRAM_write_data, SRAM_we_n
    );

    // slave: M2 FSM, DPRAM and SRAM arbiter side
    modport slave (
        output WS_start, WS_read_data,
        input  WS_done, WS_frame_done, WS_read_address,
               SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/ws_write_block.sv
// Writes one 8x8 block of clipped S values from DPRAM to SRAM, two pixels per word,
// and walks its block position through the Y, U and V segments of the frame.
module ws_write_block #(
    parameter logic [6:0]  DP_OFFSET = 7'd0,
    parameter logic [17:0] Y_BASE    = 18'd0,
    parameter logic [17:0] U_BASE    = 18'd38400,
    parameter logic [17:0] V_BASE    = 18'd57600
) (
    input  logic              CLOCK_50_I,
    input  logic              Reset,
    ws_write_block_if.master  ws
);
    localparam int unsigned CW = 7;
    localparam int unsigned AW = 18;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LI     = 2'd1;
    localparam logic [1:0] S_COMMON = 2'd2;
    localparam logic [1:0] S_LO     = 2'd3;

    localparam logic [1:0] SEG_Y = 2'd0;
    localparam logic [1:0] SEG_U = 2'd1;
    localparam logic [1:0] SEG_V = 2'd2;

    localparam logic [CW-1:0] LI_LAST     = 7'd3;
    localparam logic [CW-1:0] COMMON_LAST = 7'd64;
    localparam logic [CW-1:0] LO_LAST     = 7'd66;
    localparam logic [CW-1:0] FIRST_WR    = 7'd3;
    localparam logic [4:0]    RB_LAST     = 5'd29;

    logic [1:0]    state, state_n;
    logic [CW-1:0] cyc, cyc_n;
    logic [6:0]    rd_addr, rd_addr_n;
    logic [7:0]    even_px, even_px_n;
    logic [AW-1:0] sram_addr, sram_addr_n;
    logic [15:0]   sram_data, sram_data_n;
    logic          we_n, we_n_n;
    logic          done, done_n;
    logic          frame_done, frame_done_n;
    logic [5:0]    cb, cb_n;
    logic [4:0]    rb, rb_n;
    logic [1:0]    seg, seg_n;

    logic [4:0]    word_idx;
    logic [7:0]    row, col;
    logic [AW-1:0] seg_base, row_off, word_addr;
    logic [5:0]    c_end;

    function automatic logic [7:0] clip8(input logic [31:0] s);
        if (s[31])
            return 8'd0;
        else if (|s[30:8])
            return 8'hFF;
        else
            return s[7:0];
    endfunction

    // Word j is registered on odd cycle 2j+3, so cyc[6:1] = j+1 there
    always_comb begin
        word_idx  = 5'(cyc[6:1] - 6'd1);
        row       = {rb, word_idx[4:2]};
        col       = {cb, word_idx[1:0]};
        c_end     = (seg == SEG_Y) ? 6'd39 : 6'd19;
        case (seg)
            SEG_Y:   seg_base = Y_BASE;
            SEG_U:   seg_base = U_BASE;
            default: seg_base = V_BASE;
        endcase
        if (seg == SEG_Y)
            row_off = AW'({row, 7'b0}) + AW'({row, 5'b0});
        else
            row_off = AW'({row, 6'b0}) + AW'({row, 4'b0});
        word_addr = seg_base + row_off + AW'(col);
    end

    // Next-state, datapath and block-advance logic
    always_comb begin
        state_n      = state;
        cyc_n        = cyc;
        rd_addr_n    = rd_addr;
        even_px_n    = even_px;
        sram_addr_n  = sram_addr;
        sram_data_n  = sram_data;
        we_n_n       = 1'b1;
        done_n       = 1'b0;
        frame_done_n = 1'b0;
        cb_n         = cb;
        rb_n         = rb;
        seg_n        = seg;

        if (state == S_IDLE) begin
            if (ws.WS_start) begin
                state_n   = S_LI;
                cyc_n     = 7'd1;
                rd_addr_n = DP_OFFSET;
            end
        end else begin
            cyc_n = cyc + 7'd1;
            rd_addr_n = (cyc < COMMON_LAST) ? DP_OFFSET + cyc : DP_OFFSET;
            if (!cyc[0])
                even_px_n = clip8(ws.WS_read_data);
            else if (cyc >= FIRST_WR) begin
                sram_data_n = {even_px, clip8(ws.WS_read_data)};
                sram_addr_n = word_addr;
                we_n_n      = 1'b0;
            end
        end

        case (state)
            S_LI:     if (cyc == LI_LAST) state_n = S_COMMON;
            S_COMMON: if (cyc == COMMON_LAST) state_n = S_LO;
            S_LO: begin
                if (cyc == LO_LAST) begin
                    state_n = S_IDLE;
                    cyc_n   = '0;
                    done_n  = 1'b1;
                    if (cb == c_end) begin
                        cb_n = '0;
                        if (rb == RB_LAST) begin
                            rb_n = '0;
                            case (seg)
                                SEG_Y:   seg_n = SEG_U;
                                SEG_U:   seg_n = SEG_V;
                                default: begin
                                    seg_n        = SEG_Y;
                                    frame_done_n = 1'b1;
                                end
                            endcase
                        end else begin
                            rb_n = rb + 5'd1;
                        end
                    end else begin
                        cb_n = cb + 6'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            cyc        <= '0;
            rd_addr    <= DP_OFFSET;
            even_px    <= '0;
            sram_addr  <= '0;
            sram_data  <= '0;
            we_n       <= 1'b1;
            done       <= 1'b0;
            frame_done <= 1'b0;
            cb         <= '0;
            rb         <= '0;
            seg        <= SEG_Y;
        end else begin
            state      <= state_n;
            cyc        <= cyc_n;
            rd_addr    <= rd_addr_n;
            even_px    <= even_px_n;
            sram_addr  <= sram_addr_n;
            sram_data  <= sram_data_n;
            we_n       <= we_n_n;
            done       <= done_n;
            frame_done <= frame_done_n;
            cb         <= cb_n;
            rb         <= rb_n;
            seg        <= seg_n;
        end
    end

    assign ws.WS_done         = done;
    assign ws.WS_frame_done   = frame_done;
    assign ws.WS_read_address = rd_addr;
    assign ws.SRAM_address    = sram_addr;
    assign ws.SRAM_write_data = sram_data;
    assign ws.SRAM_we_n       = we_n;

endmodule
